// File: rtl/riscv_dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the FSM state encoding, the wait-counter width and the byte-enable legality check.
package riscv_dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int WS_BITS = 4;

    // A legal pattern is one naturally aligned, contiguous run of 1/2/4/8 lanes that fits in nbytes.
    function automatic logic be_legal(input logic [7:0] be, input int nbytes);
        logic ok;
        int   mask;
        ok = 1'b0;
        for (int sz = 1; sz <= 8; sz = sz * 2) begin
            for (int pos = 0; pos < 8; pos = pos + sz) begin
                mask = ((1 << sz) - 1) << pos;
                if ((pos + sz <= nbytes) && (be == 8'(mask))) begin
                    ok = 1'b1;
                end
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/riscv_ram_1rw_be.sv
// Single-port synchronous RAM with per-byte write enables.
// Kept as its own module so a technology macro can replace it.
module riscv_ram_1rw_be #(
   parameter int XLEN      = 32,
   parameter int DEPTH     = 1024,
   parameter     INIT_FILE = ""
) (
   input  logic                     clk,
   input  logic                     en,
   input  logic                     we,
   input  logic [XLEN/8-1:0]        be,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [XLEN-1:0]          d,
   output logic [XLEN-1:0]          q
);

   localparam int NB = XLEN / 8;

   logic [XLEN-1:0] mem [DEPTH];

   // The read register only moves on a read, so q holds the last read word.
   // Writes update only the byte lanes whose enable bit is set.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < NB; i++) begin
               if (be[i]) begin
                  mem[addr][8*i +: 8] <= d[8*i +: 8];
               end
            end
         end else begin
            q <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/riscv_dmem_resp.sv
// Responder end of the core data-memory bus: wait-state FSM, request capture and
// fault checks in front of a byte-enabled RAM.
module riscv_dmem_resp
    import riscv_dmem_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              DEPTH       = 1024,
    parameter logic [XLEN-1:0] BASE_ADDR   = '0,
    parameter int              WAIT_STATES = 1,
    parameter                  INIT_FILE   = ""
) (
    input  logic              rstn,
    input  logic              clk,
    input  logic              dmem_req,
    input  logic [XLEN-1:0]   dmem_adr,
    input  logic [XLEN-1:0]   dmem_d,
    input  logic              dmem_we,
    input  logic [XLEN/8-1:0] dmem_be,
    output logic [XLEN-1:0]   dmem_q,
    output logic              dmem_ack,
    output logic              dmem_misaligned,
    output logic              dmem_page_fault
);

    localparam int              NB   = XLEN / 8;
    localparam int              LB   = $clog2(NB);
    localparam int              AW   = $clog2(DEPTH);
    localparam logic [XLEN:0]   SPAN = (XLEN + 1)'(DEPTH * NB);

    state_t               state;
    logic [WS_BITS-1:0]   cnt;
    logic [AW-1:0]        idx_q;
    logic [XLEN-1:0]      d_q;
    logic                 we_q;
    logic [NB-1:0]        be_q;
    logic                 rd_seen;

    logic [XLEN-1:0]      offset;
    logic                 page_fault_c;
    logic                 misaligned_c;
    logic                 error_c;
    logic                 fire_now;
    logic                 fire_wait;
    logic                 ram_en;
    logic                 ram_we;
    logic [AW-1:0]        ram_addr;
    logic [XLEN-1:0]      ram_d;
    logic [NB-1:0]        ram_be;
    logic [XLEN-1:0]      ram_q;

    assign offset       = dmem_adr - BASE_ADDR;
    assign page_fault_c = (dmem_adr < BASE_ADDR) || ({1'b0, offset} >= SPAN);
    assign misaligned_c = !be_legal(8'(dmem_be), NB);
    assign error_c      = page_fault_c || misaligned_c;

    // The RAM is touched only on the edge that enters RESP; with no wait states that is the accept edge.
    assign fire_now  = (state == IDLE) && dmem_req && !error_c && (WAIT_STATES == 0);
    assign fire_wait = (state == WAIT) && (cnt == '0);
    assign ram_en    = fire_now || fire_wait;
    assign ram_we    = fire_now ? dmem_we : we_q;
    assign ram_addr  = fire_now ? offset[AW+LB-1:LB] : idx_q;
    assign ram_d     = fire_now ? dmem_d : d_q;
    assign ram_be    = fire_now ? dmem_be : be_q;

    assign dmem_q = rd_seen ? ram_q : '0;

    riscv_ram_1rw_be #(
        .XLEN      (XLEN),
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .be   (ram_be),
        .addr (ram_addr),
        .d    (ram_d),
        .q    (ram_q)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state           <= IDLE;
            cnt             <= '0;
            idx_q           <= '0;
            d_q             <= '0;
            we_q            <= 1'b0;
            be_q            <= '0;
            rd_seen         <= 1'b0;
            dmem_ack        <= 1'b0;
            dmem_misaligned <= 1'b0;
            dmem_page_fault <= 1'b0;
        end else begin
            dmem_ack        <= 1'b0;
            dmem_misaligned <= 1'b0;
            dmem_page_fault <= 1'b0;
            if (ram_en && !ram_we) begin
                rd_seen <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (dmem_req) begin
                        idx_q <= offset[AW+LB-1:LB];
                        d_q   <= dmem_d;
                        we_q  <= dmem_we;
                        be_q  <= dmem_be;
                        if (error_c) begin
                            state           <= RESP;
                            dmem_ack        <= 1'b1;
                            dmem_misaligned <= misaligned_c;
                            dmem_page_fault <= page_fault_c;
                        end else if (WAIT_STATES == 0) begin
                            state    <= RESP;
                            dmem_ack <= 1'b1;
                        end else begin
                            cnt   <= WS_BITS'(WAIT_STATES - 1);
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state    <= RESP;
                        dmem_ack <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_dmem_resp.sv
// Scoreboard bench for riscv_dmem_resp: directed cases then random traffic,
// with expected responses produced by a word-array model of the memory.
module tb_riscv_dmem_resp;

    localparam int          DEPTH = 1024;
    localparam int          WS    = 2;
    localparam logic [31:0] SPAN  = 32'(DEPTH * 4);

    typedef struct {
        string       name;
        logic        mis;
        logic        pf;
        logic [31:0] q;
        bit          q_known;
        int          ack_cyc;
    } exp_t;

    logic        clk      = 1'b0;
    logic        rstn     = 1'b1;
    logic        dmem_req = 1'b0;
    logic [31:0] dmem_adr = '0;
    logic [31:0] dmem_d   = '0;
    logic        dmem_we  = 1'b0;
    logic [3:0]  dmem_be  = '0;
    logic [31:0] dmem_q;
    logic        dmem_ack;
    logic        dmem_misaligned;
    logic        dmem_page_fault;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] mem_model [int];
    logic [3:0]  mem_known [int];
    logic [31:0] model_q       = '0;
    bit          model_q_known = 1'b1;
    int          last_ack      = -10;
    int          cyc           = 0;
    int          tests         = 0;
    int          fails         = 0;
    logic [3:0]  legal_be [7]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

    riscv_dmem_resp #(
        .XLEN        (32),
        .DEPTH       (DEPTH),
        .BASE_ADDR   (32'h0),
        .WAIT_STATES (WS),
        .INIT_FILE   ("")
    ) dut (
        .rstn            (rstn),
        .clk             (clk),
        .dmem_req        (dmem_req),
        .dmem_adr        (dmem_adr),
        .dmem_d          (dmem_d),
        .dmem_we         (dmem_we),
        .dmem_be         (dmem_be),
        .dmem_q          (dmem_q),
        .dmem_ack        (dmem_ack),
        .dmem_misaligned (dmem_misaligned),
        .dmem_page_fault (dmem_page_fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every ack pops one expected response; flags must stay low between acks.
    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            if (dmem_ack === 1'b1) begin
                if (sb.size() == 0) begin
                    check_output("ack_without_request", 32'(sb.size()), 32'd1);
                end else begin
                    mon_e = sb.pop_front();
                    check_output({mon_e.name, "_ack_cycle"}, 32'(cyc), 32'(mon_e.ack_cyc));
                    check_output({mon_e.name, "_misaligned"}, 32'(dmem_misaligned), 32'(mon_e.mis));
                    check_output({mon_e.name, "_page_fault"}, 32'(dmem_page_fault), 32'(mon_e.pf));
                    if (mon_e.q_known) begin
                        check_output({mon_e.name, "_q"}, dmem_q, mon_e.q);
                    end
                end
            end else begin
                check_output("flags_outside_ack", {30'b0, dmem_misaligned, dmem_page_fault}, 32'd0);
            end
        end
    end

    // Called on a falling edge; predicts the response, drives the request and waits for its ack.
    task automatic apply_stimulus(input string name, input logic [31:0] adr, input logic [31:0] d,
                                  input logic we, input logic [3:0] be, input bit hold);
        exp_t        e;
        int          accept;
        int          w;
        int          waited;
        logic [31:0] word;
        logic [3:0]  known;
        e.name  = name;
        e.mis   = !(be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111});
        e.pf    = (adr >= SPAN);
        accept  = (cyc + 1 > last_ack + 2) ? cyc + 1 : last_ack + 2;
        e.ack_cyc = accept + ((e.mis || e.pf) ? 0 : WS);
        if (!(e.mis || e.pf)) begin
            w     = int'(adr >> 2);
            word  = mem_model.exists(w) ? mem_model[w] : 32'h0;
            known = mem_known.exists(w) ? mem_known[w] : 4'h0;
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        word[8*b +: 8] = d[8*b +: 8];
                        known[b]       = 1'b1;
                    end
                end
                mem_model[w] = word;
                mem_known[w] = known;
            end else begin
                model_q       = word;
                model_q_known = (known == 4'hF);
            end
        end
        e.q       = model_q;
        e.q_known = model_q_known;
        sb.push_back(e);
        dmem_adr = adr;
        dmem_d   = d;
        dmem_we  = we;
        dmem_be  = be;
        dmem_req = 1'b1;
        waited   = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (dmem_ack !== 1'b1 && waited < 40);
        if (dmem_ack !== 1'b1) begin
            check_output({name, "_ack_timeout"}, 32'(dmem_ack), 32'd1);
            sb.delete();
        end
        last_ack = cyc;
        if (!hold) begin
            dmem_req = 1'b0;
        end
    endtask

    // Starts a write, then resets while it sits in its wait states; the write must never land.
    task automatic reset_mid_wait(input logic [31:0] adr, input logic [31:0] d);
        int accept;
        accept   = (cyc + 1 > last_ack + 2) ? cyc + 1 : last_ack + 2;
        dmem_adr = adr;
        dmem_d   = d;
        dmem_we  = 1'b1;
        dmem_be  = 4'hF;
        dmem_req = 1'b1;
        while (cyc < accept) @(negedge clk);
        rstn     = 1'b0;
        dmem_req = 1'b0;
        #1;
        check_output("reset_mid_wait_ack", 32'(dmem_ack), 32'd0);
        check_output("reset_mid_wait_q", dmem_q, 32'h0);
        check_output("reset_mid_wait_flags", {30'b0, dmem_misaligned, dmem_page_fault}, 32'd0);
        model_q       = '0;
        model_q_known = 1'b1;
        last_ack      = -10;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        logic [31:0] adr;
        logic [3:0]  be;
        bit          hold;
        #2 rstn = 1'b0;
        #1;
        check_output("reset_ack", 32'(dmem_ack), 32'd0);
        check_output("reset_q", dmem_q, 32'h0);
        check_output("reset_flags", {30'b0, dmem_misaligned, dmem_page_fault}, 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        apply_stimulus("wr_full", 32'h10, 32'hDEADBEEF, 1'b1, 4'b1111, 1'b0);
        apply_stimulus("rd_full", 32'h10, 32'h0, 1'b0, 4'b1111, 1'b0);
        apply_stimulus("wr_byte", 32'h11, 32'h0000AA00, 1'b1, 4'b0010, 1'b0);
        apply_stimulus("rd_merged", 32'h10, 32'h0, 1'b0, 4'b1111, 1'b0);
        apply_stimulus("mis_0110", 32'h10, 32'h0, 1'b1, 4'b0110, 1'b0);
        apply_stimulus("mis_0000", 32'h10, 32'h0, 1'b0, 4'b0000, 1'b0);
        apply_stimulus("rd_after_mis", 32'h10, 32'h0, 1'b0, 4'b1111, 1'b0);
        apply_stimulus("pf_1000", 32'h1000, 32'h0, 1'b0, 4'b1111, 1'b0);
        apply_stimulus("wr_top", 32'hFFC, 32'hCAFEF00D, 1'b1, 4'b1111, 1'b0);
        apply_stimulus("rd_top", 32'hFFC, 32'h0, 1'b0, 4'b1111, 1'b0);
        apply_stimulus("pf_and_mis", 32'h2001, 32'h0, 1'b1, 4'b0101, 1'b0);

        reset_mid_wait(32'h10, 32'h12345678);
        @(negedge clk);
        apply_stimulus("rd_after_reset", 32'h10, 32'h0, 1'b0, 4'b1111, 1'b0);

        apply_stimulus("b2b_wr0", 32'h20, 32'h11111111, 1'b1, 4'b1111, 1'b1);
        apply_stimulus("b2b_wr1", 32'h24, 32'h22222222, 1'b1, 4'b1111, 1'b1);
        apply_stimulus("b2b_rd0", 32'h20, 32'h0, 1'b0, 4'b1111, 1'b1);
        apply_stimulus("b2b_rd1", 32'h24, 32'h0, 1'b0, 4'b1111, 1'b0);

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0:       adr = 32'h1000 + 32'($urandom_range(0, 4095));
                1:       adr = $urandom | 32'h8000_0000;
                default: adr = ($urandom_range(0, 1) ? 32'h0 : 32'hF80) + 32'($urandom_range(0, 127));
            endcase
            be   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : legal_be[$urandom_range(0, 6)];
            hold = (i != 299) && ($urandom_range(0, 1) == 1);
            apply_stimulus($sformatf("rnd%0d", i), adr, $urandom, 1'($urandom_range(0, 1)), be, hold);
            if (!hold) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        repeat (4) @(negedge clk);
        check_output("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        check_output("watchdog_expired", 32'd1, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
